// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (master) and the fetch_queue (slave), including
// the decode-side output view and dequeue count.
interface fetch_queue_if #(
    parameter int DATA_W = 64,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2
);
    logic                         flush;
    logic [$clog2(IN_W+1)-1:0]    in_cnt;
    logic [IN_W*DATA_W-1:0]       in_data;
    logic                         in_ready;
    logic [$clog2(OUT_W+1)-1:0]   out_cnt;
    logic [OUT_W*DATA_W-1:0]      out_data;
    logic [$clog2(OUT_W+1)-1:0]   deq_cnt;

    modport master (
        output flush, in_cnt, in_data, deq_cnt,
        input  in_ready, out_cnt, out_data
    );

    modport slave (
        input  flush, in_cnt, in_data, deq_cnt,
        output in_ready, out_cnt, out_data
    );
endinterface

// File: rtl/fetch_queue.sv
// Multi-lane in-order instruction buffer between fetch and decode with one-cycle flush.
// Optional FETCH_QUEUE_BYPASS_EN: accepted incoming lanes appear on the output view the same cycle.
module fetch_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2
) (
    input  logic            clk,
    input  logic            resetn,
    fetch_queue_if.slave    q
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int AW  = CW + 1;
    localparam int ICW = $clog2(IN_W + 1);
    localparam int OCW = $clog2(OUT_W + 1);

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic                    in_ready;
    logic                    push_ok;
    logic [ICW-1:0]          push_cnt;
    logic [AW-1:0]           avail;
    logic [OCW-1:0]          out_cnt;
    logic [OCW-1:0]          deq_eff;
    logic [OUT_W*DATA_W-1:0] out_data;

    // in_ready looks only at the registered count, so decode never reaches fetch combinationally.
    always_comb begin
        in_ready = (int'(count_q) + IN_W <= DEPTH);
        push_ok  = in_ready && !q.flush && resetn;
        push_cnt = '0;
        if (push_ok) begin
            push_cnt = (int'(q.in_cnt) > IN_W) ? ICW'(IN_W) : q.in_cnt;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        avail = AW'(count_q) + AW'(push_cnt);
`else
        avail = AW'(count_q);
`endif
        out_cnt = (int'(avail) > OUT_W) ? OCW'(OUT_W) : OCW'(avail);
        deq_eff = (q.deq_cnt > out_cnt) ? out_cnt : q.deq_cnt;

        if (q.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Bypassed lanes are written anyway; rd_ptr then steps over them with the pop.
            rd_ptr_d = rd_ptr_q + PW'(deq_eff);
            wr_ptr_d = wr_ptr_q + PW'(push_cnt);
            count_d  = count_q + CW'(push_cnt) - CW'(deq_eff);
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < OUT_W; j++) begin
            if (j < int'(out_cnt)) begin
`ifdef FETCH_QUEUE_BYPASS_EN
                if (j < int'(count_q)) begin
                    out_data[j*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PW'(j)];
                end else begin
                    out_data[j*DATA_W +: DATA_W] = q.in_data[(j - int'(count_q))*DATA_W +: DATA_W];
                end
`else
                out_data[j*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PW'(j)];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_W; i++) begin
            if (i < int'(push_cnt)) begin
                mem_q[wr_ptr_q + PW'(i)] <= q.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign q.in_ready = in_ready;
    assign q.out_cnt  = out_cnt;
    assign q.out_data = out_data;

    a_push_when_full: assert property (@(posedge clk) disable iff (!resetn)
        (q.in_cnt != '0) |-> in_ready);
    a_over_dequeue: assert property (@(posedge clk) disable iff (!resetn)
        q.deq_cnt <= out_cnt);
endmodule
